id_ex_scoreboard: RTL

ID_EX_SCOREBOARD -- requirements
Module: id_ex_scoreboard

---
 rtl/id_ex_scoreboard_if.sv | 47 ++++
 rtl/id_ex_scoreboard.sv | 125 ++++++++++++
 2 files changed

// File: rtl/id_ex_scoreboard_if.sv
// ID/EX boundary bundle: decode-side request, writeback commit, EX handshake
// and the registered ID/EX payload plus scoreboard observation outputs.
interface id_ex_scoreboard_if;
    logic        id_valid;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        uses_rs;
    logic        uses_rt;
    logic [4:0]  wr_addr;
    logic        reg_write_cu;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic [31:0] sgn_ext_imm;
    logic [7:0]  ctrl_in;
    logic        wb_write;
    logic [4:0]  wb_addr;
    logic        ex_ready;
    logic        flush;

    logic        ex_valid;
    logic [31:0] ex_rd_data1;
    logic [31:0] ex_rd_data2;
    logic [31:0] ex_imm;
    logic [4:0]  ex_wr_addr;
    logic        ex_reg_write;
    logic [7:0]  ex_ctrl;
    logic        id_stall;
    logic [31:0] busy_vec;
    logic [1:0]  state;
    logic [15:0] stall_count;

    modport master (
        output id_valid, rs_addr, rt_addr, uses_rs, uses_rt, wr_addr, reg_write_cu,
               rd_data1, rd_data2, sgn_ext_imm, ctrl_in, wb_write, wb_addr,
               ex_ready, flush,
        input  ex_valid, ex_rd_data1, ex_rd_data2, ex_imm, ex_wr_addr, ex_reg_write,
               ex_ctrl, id_stall, busy_vec, state, stall_count
    );

    modport slave (
        input  id_valid, rs_addr, rt_addr, uses_rs, uses_rt, wr_addr, reg_write_cu,
               rd_data1, rd_data2, sgn_ext_imm, ctrl_in, wb_write, wb_addr,
               ex_ready, flush,
        output ex_valid, ex_rd_data1, ex_rd_data2, ex_imm, ex_wr_addr, ex_reg_write,
               ex_ctrl, id_stall, busy_vec, state, stall_count
    );
endinterface

// File: rtl/id_ex_scoreboard.sv
// ID/EX pipeline register with a register-busy scoreboard.
// Decode is held while a source (RAW) or destination (WAW) register has an
// outstanding writer, or while EX applies backpressure.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | last cycle had no stall cause (idle, issued or flushed)
//   RAW   | last cycle the decode instruction hit a busy register
//   BP    | last cycle EX was not ready for a hazard-free instruction
module id_ex_scoreboard (
    input  logic              clk,
    input  logic              reset,
    id_ex_scoreboard_if.slave bus
);

    typedef enum logic [1:0] {
        RUN = 2'd0,
        RAW = 2'd1,
        BP  = 2'd2
    } state_t;

    logic [31:0] r_busy;
    state_t      r_state;
    logic [15:0] r_stall_count;
    logic        r_ex_valid;
    logic [31:0] r_ex_rd_data1;
    logic [31:0] r_ex_rd_data2;
    logic [31:0] r_ex_imm;
    logic [4:0]  r_ex_wr_addr;
    logic        r_ex_reg_write;
    logic [7:0]  r_ex_ctrl;

    logic        w_rs_hit;
    logic        w_rt_hit;
    logic        w_wr_hit;
    logic        w_dst_nz;
    logic        w_hazard;
    logic        w_issue;
    logic        w_stall;
    logic [31:0] w_set_vec;
    logic [31:0] w_clr_vec;
    logic [31:0] w_busy_next;
    state_t      w_state_next;

    // Hazards look only at the registered scoreboard: a writeback clear is
    // not bypassed and becomes visible one cycle later.
    assign w_dst_nz = (bus.wr_addr != 5'd0);
    assign w_rs_hit = bus.uses_rs & (bus.rs_addr != 5'd0) & r_busy[bus.rs_addr];
    assign w_rt_hit = bus.uses_rt & (bus.rt_addr != 5'd0) & r_busy[bus.rt_addr];
    assign w_wr_hit = bus.reg_write_cu & w_dst_nz & r_busy[bus.wr_addr];
    assign w_hazard = bus.id_valid & (w_rs_hit | w_rt_hit | w_wr_hit);
    assign w_issue  = bus.id_valid & ~w_hazard & bus.ex_ready & ~bus.flush;
    assign w_stall  = bus.id_valid & ~w_issue & ~bus.flush;

    // Set is applied after clear so a same-edge collision leaves the bit set;
    // r0 is never tracked.
    assign w_set_vec   = (w_issue & bus.reg_write_cu & w_dst_nz) ? (32'd1 << bus.wr_addr) : 32'd0;
    assign w_clr_vec   = (bus.wb_write & (bus.wb_addr != 5'd0)) ? (32'd1 << bus.wb_addr) : 32'd0;
    assign w_busy_next = ((r_busy & ~w_clr_vec) | w_set_vec) & ~32'd1;

    // Next-state selection; a RAW/WAW hit outranks backpressure.
    always_comb begin
        w_state_next = RUN;
        if (bus.id_valid & w_hazard & ~bus.flush) begin
            w_state_next = RAW;
        end else if (bus.id_valid & ~bus.ex_ready & ~bus.flush) begin
            w_state_next = BP;
        end
    end

    // Scoreboard, stall-reason state and saturating stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy        <= 32'd0;
            r_state       <= RUN;
            r_stall_count <= 16'd0;
        end else begin
            r_busy  <= w_busy_next;
            r_state <= w_state_next;
            if (w_stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    // ID/EX payload: load on issue, bubble when EX is ready with nothing to
    // issue, hold everything (even under flush) when EX is not ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_valid     <= 1'b0;
            r_ex_reg_write <= 1'b0;
            r_ex_rd_data1  <= 32'd0;
            r_ex_rd_data2  <= 32'd0;
            r_ex_imm       <= 32'd0;
            r_ex_wr_addr   <= 5'd0;
            r_ex_ctrl      <= 8'd0;
        end else if (bus.ex_ready) begin
            if (w_issue) begin
                r_ex_valid     <= 1'b1;
                r_ex_reg_write <= bus.reg_write_cu & w_dst_nz;
                r_ex_rd_data1  <= bus.rd_data1;
                r_ex_rd_data2  <= bus.rd_data2;
                r_ex_imm       <= bus.sgn_ext_imm;
                r_ex_wr_addr   <= bus.wr_addr;
                r_ex_ctrl      <= bus.ctrl_in;
            end else begin
                r_ex_valid     <= 1'b0;
                r_ex_reg_write <= 1'b0;
            end
        end
    end

    assign bus.ex_valid     = r_ex_valid;
    assign bus.ex_rd_data1  = r_ex_rd_data1;
    assign bus.ex_rd_data2  = r_ex_rd_data2;
    assign bus.ex_imm       = r_ex_imm;
    assign bus.ex_wr_addr   = r_ex_wr_addr;
    assign bus.ex_reg_write = r_ex_reg_write;
    assign bus.ex_ctrl      = r_ex_ctrl;
    assign bus.id_stall     = w_stall;
    assign bus.busy_vec     = r_busy;
    assign bus.state        = r_state;
    assign bus.stall_count  = r_stall_count;

endmodule
